// File: rtl/rmt_ctrl_pkg.sv
// Purpose: shared control-ring definitions for the RMT stage configurators.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: header field bit offsets, ring magic, resource types, FSM states.
package rmt_ctrl_pkg;

  localparam int MAGIC_OFF    = 64;
  localparam int MOD_ID_OFF   = 112;
  localparam int RES_TYPE_OFF = 124;
  localparam int INDEX_OFF    = 128;

  localparam logic [15:0] CTRL_MAGIC   = 16'hF1F2;
  localparam logic [3:0]  RES_KEY_OFF  = 4'd1;
  localparam logic [3:0]  RES_KEY_MASK = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DROP  = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic [15:0] magic;
    logic [7:0]  mod_id;
    logic [3:0]  res_type;
    logic [7:0]  index;
  } ctrl_hdr_t;

endpackage

// File: rtl/ctrl_hdr_decode.sv
// Purpose: extract control header fields and test whether the packet targets this module.
// Latency: combinational.
// Backpressure: none.
// Ports: tdata in (header beat); hdr out (fields), hit out (magic + module id match),
//        type_ok out (res_type is key-offset or key-mask).
module ctrl_hdr_decode
  import rmt_ctrl_pkg::*;
#(
  parameter int          DATA_WIDTH = 256,
  parameter logic [7:0]  MODULE_ID  = 8'h00
) (
  input  logic [DATA_WIDTH-1:0] tdata,
  output ctrl_hdr_t             hdr,
  output logic                  hit,
  output logic                  type_ok
);

  assign hdr.magic    = tdata[MAGIC_OFF    +: 16];
  assign hdr.mod_id   = tdata[MOD_ID_OFF   +: 8];
  assign hdr.res_type = tdata[RES_TYPE_OFF +: 4];
  assign hdr.index    = tdata[INDEX_OFF    +: 8];

  assign hit     = (hdr.magic == CTRL_MAGIC) && (hdr.mod_id == MODULE_ID);
  assign type_ok = (hdr.res_type == RES_KEY_OFF) || (hdr.res_type == RES_KEY_MASK);

  // Bits of the header beat that carry no field for this decoder.
  logic unused_bits;
  assign unused_bits = ^{tdata[MAGIC_OFF-1:0],
                         tdata[MOD_ID_OFF-1:MAGIC_OFF+16],
                         tdata[RES_TYPE_OFF-1:MOD_ID_OFF+8],
                         tdata[DATA_WIDTH-1:INDEX_OFF+8]};

endmodule

// File: rtl/key_extract_cfg_ctrl.sv
// Purpose: turn control-ring packets addressed to this key extractor into table writes; forward the rest.
// Latency: 1 cycle for forwarded beats and for write strobes.
// Backpressure: none; every input beat is accepted.
// Ports: c_s_axis_* in (control ring), c_m_axis_* out (ring onward), key_off_wr_* / key_mask_wr_* out
//        (table write ports), cfg_wr_cnt / cfg_err_cnt out (write and malformed-packet counters).
module key_extract_cfg_ctrl
  import rmt_ctrl_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int STAGE_ID             = 0,
  parameter int KEY_EX_ID            = 1,
  parameter int KEY_OFF              = 18,
  parameter int KEY_LEN              = 197,
  parameter int KEY_OFF_ADDR_WIDTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_s_axis_tkeep,
  input  logic                                 c_s_axis_tvalid,
  input  logic                                 c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
  output logic                                 c_m_axis_tvalid,
  output logic                                 c_m_axis_tlast,
  output logic                                 key_off_wr_en,
  output logic [KEY_OFF_ADDR_WIDTH-1:0]        key_off_wr_addr,
  output logic [KEY_OFF-1:0]                   key_off_wr_data,
  output logic                                 key_mask_wr_en,
  output logic [KEY_OFF_ADDR_WIDTH-1:0]        key_mask_wr_addr,
  output logic [KEY_LEN-1:0]                   key_mask_wr_data,
  output logic [15:0]                          cfg_wr_cnt,
  output logic [7:0]                           cfg_err_cnt
);

  localparam logic [7:0] MODULE_ID = {STAGE_ID[4:0], KEY_EX_ID[2:0]};
  localparam logic [KEY_OFF_ADDR_WIDTH-1:0] PTR_ONE = 1;

  ctrl_state_e state, next_state;
  ctrl_hdr_t   hdr;
  logic        hit, type_ok;

  logic                          fwd_beat, wr_beat, err_inc, ptr_load;
  logic [KEY_OFF_ADDR_WIDTH-1:0] wr_ptr;
  logic                          sel_mask;   // res_type latched at the header

  ctrl_hdr_decode #(
    .DATA_WIDTH (C_S_AXIS_DATA_WIDTH),
    .MODULE_ID  (MODULE_ID)
  ) u_hdr_decode (
    .tdata   (c_s_axis_tdata),
    .hdr     (hdr),
    .hit     (hit),
    .type_ok (type_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    fwd_beat   = 1'b0;
    wr_beat    = 1'b0;
    err_inc    = 1'b0;
    ptr_load   = 1'b0;
    if (c_s_axis_tvalid) begin
      case (state)
        ST_IDLE: begin
          if (!hit) begin
            fwd_beat = 1'b1;
            if (!c_s_axis_tlast) next_state = ST_FWD;
          end else if (type_ok) begin
            // A single-beat matching packet carries no payload: consumed, nothing written.
            if (!c_s_axis_tlast) begin
              next_state = ST_WRITE;
              ptr_load   = 1'b1;
            end
          end else begin
            err_inc = 1'b1;
            if (!c_s_axis_tlast) next_state = ST_DROP;
          end
        end
        ST_FWD: begin
          fwd_beat = 1'b1;
          if (c_s_axis_tlast) next_state = ST_IDLE;
        end
        ST_WRITE: begin
          wr_beat = 1'b1;
          if (c_s_axis_tlast) next_state = ST_IDLE;
        end
        ST_DROP: begin
          if (c_s_axis_tlast) next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_m_axis_tdata   <= '0;
      c_m_axis_tuser   <= '0;
      c_m_axis_tkeep   <= '0;
      c_m_axis_tvalid  <= 1'b0;
      c_m_axis_tlast   <= 1'b0;
      key_off_wr_en    <= 1'b0;
      key_off_wr_addr  <= '0;
      key_off_wr_data  <= '0;
      key_mask_wr_en   <= 1'b0;
      key_mask_wr_addr <= '0;
      key_mask_wr_data <= '0;
      cfg_wr_cnt       <= '0;
      cfg_err_cnt      <= '0;
      wr_ptr           <= '0;
      sel_mask         <= 1'b0;
    end else begin
      c_m_axis_tvalid <= fwd_beat;
      if (fwd_beat) begin
        c_m_axis_tdata <= c_s_axis_tdata;
        c_m_axis_tuser <= c_s_axis_tuser;
        c_m_axis_tkeep <= c_s_axis_tkeep;
        c_m_axis_tlast <= c_s_axis_tlast;
      end

      key_off_wr_en  <= wr_beat && !sel_mask;
      key_mask_wr_en <= wr_beat &&  sel_mask;

      if (ptr_load) begin
        wr_ptr   <= hdr.index[KEY_OFF_ADDR_WIDTH-1:0];
        sel_mask <= (hdr.res_type == RES_KEY_MASK);
      end else if (wr_beat) begin
        wr_ptr <= wr_ptr + PTR_ONE;   // wraps modulo table depth
      end

      if (wr_beat) begin
        cfg_wr_cnt <= cfg_wr_cnt + 16'd1;
        if (sel_mask) begin
          key_mask_wr_addr <= wr_ptr;
          key_mask_wr_data <= c_s_axis_tdata[KEY_LEN-1:0];
        end else begin
          key_off_wr_addr <= wr_ptr;
          key_off_wr_data <= c_s_axis_tdata[KEY_OFF-1:0];
        end
      end

      if (err_inc && (cfg_err_cnt != 8'hFF)) cfg_err_cnt <= cfg_err_cnt + 8'd1;
    end
  end

endmodule
